rr_ack_arbiter_n: RTL and testbench

RR_ACK_ARBITER_N -- requirements
Module: rr_ack_arbiter_n

---
 rtl/rr_ack_arbiter_n.sv | 151 +++++++++++++++
 tb/tb_rr_ack_arbiter_n.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rr_ack_arbiter_n.sv
// Round-robin acknowledge arbiter: grants one master waiting on this slave and forwards ack_in.
// Optional grant timeout enabled by defining the macro RR_ACK_TIMEOUT_EN.
module rr_ack_arbiter_n #(
  parameter int N_MAS  = 4,
  parameter int SW     = 2,
  parameter int TO_CYC = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SW-1:0]              s_no,
  input  logic                       ack_in,
  input  logic [N_MAS*SW-1:0]        sfor,
  input  logic [2*N_MAS-1:0]         req_stat,
  output logic [N_MAS-1:0]           ack,
  output logic                       gnt_valid,
  output logic [$clog2(N_MAS)-1:0]   gnt_id,
  output logic                       to_err
);

  localparam logic [1:0] W_ACK = 2'd2;
  localparam int         IW    = $clog2(N_MAS);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (N_MAS < 2 || N_MAS > 16 || TO_CYC < 1 || TO_CYC > 255) begin : g_param_err
    $error("rr_ack_arbiter_n: parameter out of legal range");
  end

  state_t            state_q, state_d;
  logic [N_MAS-1:0]  ack_q, ack_d;
  logic [IW-1:0]     gnt_id_q, gnt_id_d;
  logic [IW-1:0]     last_mas_q, last_mas_d;
  logic              to_err_q, to_err_d;
  logic [N_MAS-1:0]  elig_s;
  logic [IW-1:0]     win_s;
  logic [IW-1:0]     idx_s;
  logic              any_s;

`ifdef RR_ACK_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // Per-master eligibility: targets this slave and is waiting for ack.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N_MAS; i++) begin
      elig_s[i] = (sfor[i*SW +: SW] == s_no) && (req_stat[2*i +: 2] == W_ACK);
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    any_s = 1'b0;
    win_s = '0;
    idx_s = '0;
    for (int k = 1; k <= N_MAS; k++) begin
      idx_s = IW'((int'(last_mas_q) + k) % N_MAS);
      if (!any_s && elig_s[idx_s]) begin
        any_s = 1'b1;
        win_s = idx_s;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    gnt_id_d   = gnt_id_q;
    last_mas_d = last_mas_q;
    to_err_d   = 1'b0;
`ifdef RR_ACK_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d    = GRANT;
          gnt_id_d   = win_s;
          last_mas_d = win_s;
`ifdef RR_ACK_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Ack wins over withdrawal check and timeout.
        if (elig_s[gnt_id_q] && ack_in) begin
          ack_d[gnt_id_q] = 1'b1;
          state_d         = IDLE;
        end else if (!elig_s[gnt_id_q]) begin
          state_d = IDLE;
`ifdef RR_ACK_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d  = IDLE;
          to_err_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = GRANT;
        end
`else
        end else begin
          state_d = GRANT;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      gnt_id_q   <= '0;
      last_mas_q <= IW'(N_MAS - 1);
      to_err_q   <= 1'b0;
`ifdef RR_ACK_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      gnt_id_q   <= gnt_id_d;
      last_mas_q <= last_mas_d;
      to_err_q   <= to_err_d;
`ifdef RR_ACK_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign gnt_valid = (state_q == GRANT);
  assign gnt_id    = gnt_id_q;
`ifdef RR_ACK_TIMEOUT_EN
  assign to_err    = to_err_q;
`else
  assign to_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_ack_arbiter_n.sv
// Directed scoreboard bench for rr_ack_arbiter_n (N_MAS=4, SW=2, TO_CYC=3).
module tb_rr_ack_arbiter_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] s_no;
  logic       ack_in;
  logic [7:0] sfor;
  logic [7:0] req_stat;
  logic [3:0] ack;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       to_err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] ack;
    logic       gv;
    logic [1:0] id;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];

  rr_ack_arbiter_n #(.N_MAS(4), .SW(2), .TO_CYC(3)) dut (
    .clk(clk), .reset(reset), .s_no(s_no), .ack_in(ack_in),
    .sfor(sfor), .req_stat(req_stat),
    .ack(ack), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .to_err(to_err)
  );

  always #5 clk = ~clk;

  // All masters target slave 1; masters in mask wait for ack, others are in state 1.
  task automatic set_req(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      sfor[2*i +: 2]     = 2'd1;
      req_stat[2*i +: 2] = mask[i] ? 2'd2 : 2'd1;
    end
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic tick(input logic [3:0] e_ack, input logic e_gv, input logic [1:0] e_id,
                      input logic e_to, input string tag);
    exp_t e;
    sb.push_back('{ack: e_ack, gv: e_gv, id: e_id, to: e_to, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    assert (ack === e.ack) else begin
      n_err++;
      $error("FAIL %s ack observed=%b expected=%b", e.tag, ack, e.ack);
    end
    n_vec++;
    assert (gnt_valid === e.gv) else begin
      n_err++;
      $error("FAIL %s gnt_valid observed=%b expected=%b", e.tag, gnt_valid, e.gv);
    end
    n_vec++;
    assert (gnt_id === e.id) else begin
      n_err++;
      $error("FAIL %s gnt_id observed=%0d expected=%0d", e.tag, gnt_id, e.id);
    end
    n_vec++;
    assert (to_err === e.to) else begin
      n_err++;
      $error("FAIL %s to_err observed=%b expected=%b", e.tag, to_err, e.to);
    end
  endtask

  initial begin
    reset  = 1'b1;
    ack_in = 1'b0;
    s_no   = 2'd1;
    set_req(4'b0000);
    tick(4'b0000, 1'b0, 2'd0, 1'b0, "reset");
    reset = 1'b0;

    // First grant after reset goes to master 0, then master 2.
    set_req(4'b0101);
    tick(4'b0000, 1'b1, 2'd0, 1'b0, "first_gnt");
    ack_in = 1'b1;
    tick(4'b0001, 1'b0, 2'd0, 1'b0, "first_ack");
    tick(4'b0000, 1'b1, 2'd2, 1'b0, "second_gnt");
    ack_in = 1'b0;
    set_req(4'b0000);
    tick(4'b0000, 1'b0, 2'd2, 1'b0, "drop_m2");
    tick(4'b0000, 1'b0, 2'd2, 1'b0, "idle_after_drop");

    // Fairness: all eligible, ack tied high.
    reset = 1'b1;
    tick(4'b0000, 1'b0, 2'd0, 1'b0, "reset2");
    reset = 1'b0;
    set_req(4'b1111);
    ack_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(4'b0000, 1'b1, 2'(i % 4), 1'b0, "rr_gnt");
      tick(4'b0001 << (i % 4), 1'b0, 2'(i % 4), 1'b0, "rr_ack");
    end

    // Withdrawal in the same cycle as ack_in.
    ack_in = 1'b0;
    set_req(4'b0010);
    tick(4'b0000, 1'b1, 2'd1, 1'b0, "wd_gnt");
    set_req(4'b0000);
    ack_in = 1'b1;
    tick(4'b0000, 1'b0, 2'd1, 1'b0, "wd_noack");
    tick(4'b0000, 1'b0, 2'd1, 1'b0, "wd_idle");
    ack_in = 1'b0;

    set_req(4'b1000);
`ifdef RR_ACK_TIMEOUT_EN
    tick(4'b0000, 1'b1, 2'd3, 1'b0, "to_c1");
    tick(4'b0000, 1'b1, 2'd3, 1'b0, "to_c2");
    tick(4'b0000, 1'b1, 2'd3, 1'b0, "to_c3");
    tick(4'b0000, 1'b0, 2'd3, 1'b1, "to_err");
    tick(4'b0000, 1'b1, 2'd3, 1'b0, "to2_c1");
    tick(4'b0000, 1'b1, 2'd3, 1'b0, "to2_c2");
    ack_in = 1'b1;
    tick(4'b1000, 1'b0, 2'd3, 1'b0, "to2_ack_wins");
    ack_in = 1'b0;
`else
    tick(4'b0000, 1'b1, 2'd3, 1'b0, "hold_gnt");
    for (int i = 0; i < 20; i++) begin
      tick(4'b0000, 1'b1, 2'd3, 1'b0, "hold_forever");
    end
    set_req(4'b0000);
    tick(4'b0000, 1'b0, 2'd3, 1'b0, "hold_release");
`endif
    set_req(4'b0000);
    tick(4'b0000, 1'b0, 2'd3, 1'b0, "idle_m3");

    // Reset during GRANT of master 2 with ack_in high.
    set_req(4'b0100);
    tick(4'b0000, 1'b1, 2'd2, 1'b0, "rst_gnt");
    reset  = 1'b1;
    ack_in = 1'b1;
    tick(4'b0000, 1'b0, 2'd0, 1'b0, "rst_mid");
    reset  = 1'b0;
    ack_in = 1'b0;
    set_req(4'b0101);
    tick(4'b0000, 1'b1, 2'd0, 1'b0, "rst_restart_m0");
    set_req(4'b0000);
    tick(4'b0000, 1'b0, 2'd0, 1'b0, "rst_idle");

    // Wrong slave and non-waiting request states never grant.
    ack_in = 1'b1;
    sfor     = 8'b1010_1010;
    req_stat = 8'b1010_1010;
    for (int i = 0; i < 8; i++) begin
      tick(4'b0000, 1'b0, 2'd0, 1'b0, "wrong_slave");
    end
    sfor     = 8'b0101_0101;
    req_stat = 8'b1111_0100;
    for (int i = 0; i < 4; i++) begin
      tick(4'b0000, 1'b0, 2'd0, 1'b0, "not_waiting");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
